kb_matrix_scanner: RTL
======================

Name: kb_matrix_scanner

Overview:
Scans the 4x4 matrix keypad that selects board positions for the gomoku game logic. Drives one column low at a time and samples the active-low rows. Debounces whole-keypad frames and emits one-cycle press and release events with a 4-bit key code. Sits between the keypad pins and gomoku_main, and runs on the system clock with an internal scan-tick divider.

Parameters:
SCAN_DIV, 2500, system clocks per column step (1 MHz gives 400 Hz column rate and 100 Hz frame rate); must be >= 4.
DEBOUNCE_FRAMES, 2, consecutive identical frames required to accept a press or a release; range 1..7.

Ports:
clk  input  1  system clock (one clock domain)
rst  input  1  asynchronous reset, active-high
keyboard_row  input  4  keypad rows, active-low, asynchronous to clk
keyboard_col  output  4  keypad column drive, active-low one-hot
key_valid  output  1  one-cycle pulse when a debounced press is accepted
key_release  output  1  one-cycle pulse when a debounced release is accepted
key_code  output  4  code of the last accepted key, = col*4 + row; holds its value until the next press
key_held  output  1  high from the key_valid cycle up to and including the cycle before key_release

Behaviour:
- Reset (asynchronous, active-high): div_cnt=0, col_idx=0, keyboard_col=4'b1110, frame accumulator=0, state=IDLE, debounce count=0, key_valid=0, key_release=0, key_code=0, key_held=0.
- Row path: a 2-flop synchroniser on keyboard_row, which adds 2 clocks of latency. The value is inverted so that 1 = pressed.
- Divider: div_cnt counts 0..SCAN_DIV-1 and wraps. The tick is active when div_cnt==SCAN_DIV-1.
- On tick:
  - The synchronised rows are stored into the accumulator bits [col_idx*4 +: 4].
  - col_idx then increments mod 4, and keyboard_col=~(4'b0001<<col_idx) is registered.
  - Each column is therefore driven for SCAN_DIV clocks before it is sampled.
- Frame complete: on the tick where col_idx==3, the 16-bit frame is evaluated by the decoder.
  - Decoder classes: NONE (0 bits set), SINGLE(code) (exactly 1 bit set; code = bit index), MULTI (2 or more bits set).
  - The accumulator is cleared for the next frame.
- FSM, advanced only on frame-complete:
  - IDLE:
    - SINGLE(c): cand=c, cnt=1. If DEBOUNCE_FRAMES==1, accept immediately; otherwise go to CONFIRM.
    - NONE or MULTI: stay in IDLE.
  - CONFIRM:
    - SINGLE(cand): cnt++. When cnt reaches DEBOUNCE_FRAMES, accept.
    - SINGLE(other): cand=other, cnt=1, stay in CONFIRM.
    - NONE or MULTI: go to IDLE, cnt=0.
  - Accept: on the next clk, key_valid=1 for exactly one cycle, key_code=cand, key_held=1, state=HELD.
  - HELD:
    - NONE: cnt=1; go to RELEASE, or release immediately if DEBOUNCE_FRAMES==1.
    - SINGLE of any key, or MULTI: stay in HELD. No new event is generated (no rollover).
  - RELEASE:
    - NONE: cnt++. When cnt reaches DEBOUNCE_FRAMES, release.
    - Any pressed key: return to HELD.
  - Release: on the next clk, key_release=1 for one cycle, key_held=0, state=IDLE. key_code is unchanged.
- key_valid and key_release are never asserted in the same cycle, and each is at most one cycle per frame.
- Latency: a stable press is reported DEBOUNCE_FRAMES frames after the first frame that sees it, plus 1 clk.
- Reset mid-operation clears any pending CONFIRM or RELEASE. No event is emitted after reset releases until a fresh debounce completes.
- The cnt width is 3 bits and saturates; it never wraps.

Decomposition:
- Shared package gomoku_kb_pkg contains:
  - the state typedef {IDLE, CONFIRM, HELD, RELEASE};
  - the frame class typedef {NONE, SINGLE, MULTI};
  - the constants KB_ROWS=4 and KB_COLS=4.
- One sub-module, kb_frame_decode: purely combinational, 16-bit frame in, class and 4-bit code out (popcount and one-hot encoding).
- Divider, column drive, synchroniser and FSM stay in kb_matrix_scanner.

Test Plan:
Bench uses SCAN_DIV=4, DEBOUNCE_FRAMES=2, so one frame = 16 clks. The keypad model pulls row r low while col c is low.
1. Reset, then release reset with no key pressed.
   - keyboard_col=1110 during reset; 1101 after 4 clks; 1011 after 8 clks.
   - All outputs 0 for 200 clks.
2. Hold key (c=1, r=2) from frame 0.
   - Exactly one key_valid pulse, key_code=6, at the end of frame 1 + 1 clk.
   - key_held=1 thereafter.
3. Press key 6 for one frame only, then release.
   - No key_valid, key_held stays 0, FSM returns to IDLE.
4. Hold key 6 for 5 frames, then release.
   - key_release pulse 2 frames after the release, key_held falls to 0, key_code stays 6.
   - No second key_valid.
5. Press keys 3 and 9 together.
   - No event.
   - Then hold key 3 alone: key_valid with code=3.
   - Add key 9 while held: no new key_valid, key_held stays 1.
6. Assert rst in CONFIRM, after key 6 has been seen for 1 frame.
   - All outputs 0 and keyboard_col=1110 immediately.
   - With key 6 still held after reset releases, key_valid arrives only after 2 full frames.

Source files
------------

// File: rtl/gomoku_kb_pkg.sv
// Shared types and constants for the gomoku keypad scanner.
// Frame bit index is col*KB_ROWS + row, which is also the reported key code.
package gomoku_kb_pkg;

    localparam int unsigned KB_ROWS = 4;
    localparam int unsigned KB_COLS = 4;
    localparam int unsigned KB_KEYS = KB_ROWS * KB_COLS;

    typedef enum logic [1:0] {
        StIdle,
        StConfirm,
        StHeld,
        StRelease
    } kb_state_e;

    typedef enum logic [1:0] {
        FrameNone,
        FrameSingle,
        FrameMulti
    } kb_frame_e;

endpackage

// File: rtl/kb_frame_decode.sv
// Classifies a full keypad frame as no key, exactly one key (with its index) or several keys.
module kb_frame_decode
    import gomoku_kb_pkg::*;
(
    input  logic [KB_KEYS-1:0] frame,
    output kb_frame_e          frame_class,
    output logic [3:0]         code
);

    logic [4:0] ones;

    always_comb begin
        ones = '0;
        code = '0;
        for (int i = 0; i < KB_KEYS; i++) begin
            if (frame[i]) begin
                ones = ones + 5'd1;
                code = 4'(i);
            end
        end
        if (ones == 5'd0) begin
            frame_class = FrameNone;
        end else if (ones == 5'd1) begin
            frame_class = FrameSingle;
        end else begin
            frame_class = FrameMulti;
        end
    end

endmodule

// File: rtl/kb_matrix_scanner.sv
// 4x4 keypad scanner: column drive, row synchroniser, frame accumulation and a
// debounce FSM producing one-cycle press/release events with a key code.
module kb_matrix_scanner
    import gomoku_kb_pkg::*;
#(
    parameter int unsigned SCAN_DIV        = 2500,
    parameter int unsigned DEBOUNCE_FRAMES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [KB_ROWS-1:0] keyboard_row,
    output logic [KB_COLS-1:0] keyboard_col,
    output logic               key_valid,
    output logic               key_release,
    output logic [3:0]         key_code,
    output logic               key_held
);

    localparam int unsigned    DivW      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DivW-1:0] DivLast  = DivW'(SCAN_DIV - 1);
    localparam logic [2:0]      DebTarget = 3'(DEBOUNCE_FRAMES);

    logic [DivW-1:0]    div_cnt_q;
    logic [1:0]         col_idx_q;
    logic [KB_ROWS-1:0] row_meta_q, row_sync_q;
    logic [KB_KEYS-1:0] acc_q, frame_now;
    kb_state_e          state_q, state_d;
    logic [2:0]         cnt_q, cnt_d, cnt_inc;
    logic [3:0]         cand_q, cand_d, code_d, accept_code;
    logic               valid_d, release_d, held_d;
    logic               do_accept, do_release;
    logic               tick, frame_done;
    kb_frame_e          frame_class;
    logic [3:0]         frame_code;

    assign tick       = (div_cnt_q == DivLast);
    assign frame_done = tick && (col_idx_q == 2'd3);
    assign cnt_inc    = (cnt_q == 3'd7) ? cnt_q : cnt_q + 3'd1;

    // Current column's rows merged in, so the last column is seen on the frame-complete tick.
    always_comb begin
        frame_now = acc_q;
        frame_now[{col_idx_q, 2'b00} +: KB_ROWS] = ~row_sync_q;
    end

    kb_frame_decode u_decode (
        .frame       (frame_now),
        .frame_class (frame_class),
        .code        (frame_code)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_q    <= '0;
            col_idx_q    <= '0;
            keyboard_col <= 4'b1110;
            row_meta_q   <= '1;
            row_sync_q   <= '1;
            acc_q        <= '0;
        end else begin
            row_meta_q <= keyboard_row;
            row_sync_q <= row_meta_q;
            div_cnt_q  <= tick ? '0 : div_cnt_q + DivW'(1);
            if (tick) begin
                col_idx_q    <= col_idx_q + 2'd1;
                keyboard_col <= ~(4'b0001 << (col_idx_q + 2'd1));
                acc_q        <= frame_done ? '0 : frame_now;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cand_d      = cand_q;
        code_d      = key_code;
        held_d      = key_held;
        valid_d     = 1'b0;
        release_d   = 1'b0;
        do_accept   = 1'b0;
        do_release  = 1'b0;
        accept_code = cand_q;
        if (frame_done) begin
            unique case (state_q)
                StIdle: begin
                    if (frame_class == FrameSingle) begin
                        cand_d      = frame_code;
                        cnt_d       = 3'd1;
                        accept_code = frame_code;
                        if (DebTarget <= 3'd1) begin
                            do_accept = 1'b1;
                        end else begin
                            state_d = StConfirm;
                        end
                    end
                end
                StConfirm: begin
                    if (frame_class == FrameSingle && frame_code == cand_q) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc >= DebTarget) begin
                            do_accept = 1'b1;
                        end
                    end else if (frame_class == FrameSingle) begin
                        cand_d = frame_code;
                        cnt_d  = 3'd1;
                    end else begin
                        state_d = StIdle;
                        cnt_d   = 3'd0;
                    end
                end
                StHeld: begin
                    if (frame_class == FrameNone) begin
                        cnt_d = 3'd1;
                        if (DebTarget <= 3'd1) begin
                            do_release = 1'b1;
                        end else begin
                            state_d = StRelease;
                        end
                    end
                end
                StRelease: begin
                    if (frame_class == FrameNone) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc >= DebTarget) begin
                            do_release = 1'b1;
                        end
                    end else begin
                        state_d = StHeld;
                    end
                end
            endcase
        end
        if (do_accept) begin
            valid_d = 1'b1;
            code_d  = accept_code;
            held_d  = 1'b1;
            state_d = StHeld;
        end
        if (do_release) begin
            release_d = 1'b1;
            held_d    = 1'b0;
            state_d   = StIdle;
            cnt_d     = 3'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            cand_q      <= '0;
            key_valid   <= 1'b0;
            key_release <= 1'b0;
            key_code    <= '0;
            key_held    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cand_q      <= cand_d;
            key_valid   <= valid_d;
            key_release <= release_d;
            key_code    <= code_d;
            key_held    <= held_d;
        end
    end

endmodule
